echo_distance: RTL and testbench

Downstream consumer of the echo pulse-width counter in the ultrasonic ranging path. It detects each new completed measurement (rising edge of the counter's `done` level) and captures the counter's `periodo` value. It converts the cycle count to whole centimetres with a sequential shift-subtract divider, then saturates the result. It publishes a registered distance with a one-cycle valid strobe, plus a hysteretic obstacle flag consumed by the motion controller.

---
 rtl/echo_distance.sv | 99 +++++++++
 tb/tb_echo_distance.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_distance.sv
// rtl/echo_distance.sv - echo pulse-width to centimetre converter
// Captures periodo on each new done edge, divides by CYC_PER_CM, saturates and flags obstacles.
module echo_distance #(
  parameter int BIT_periodo = 22,
  parameter int CYC_PER_CM  = 2900,
  parameter int MAX_CM      = 400,
  parameter int NEAR_CM     = 20,
  parameter int FAR_CM      = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BIT_periodo-1:0] periodo,
  input  logic                   done,
  output logic [8:0]             distance_cm,
  output logic                   dist_valid,
  output logic                   out_of_range,
  output logic                   obstacle,
  output logic                   busy
);

  localparam int CW = (BIT_periodo > 1) ? $clog2(BIT_periodo) : 1;
  localparam logic [BIT_periodo:0]   CYC  = (BIT_periodo+1)'(CYC_PER_CM);
  localparam logic [BIT_periodo-1:0] MAXQ = BIT_periodo'(MAX_CM);
  localparam logic [8:0]             MAX9  = 9'(MAX_CM);
  localparam logic [8:0]             NEAR9 = 9'(NEAR_CM);
  localparam logic [8:0]             FAR9  = 9'(FAR_CM);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                 state;
  logic                   done_q;
  logic [BIT_periodo-1:0] dividend;
  logic [BIT_periodo-1:0] quot;
  // Held remainder is always below CYC_PER_CM, so BIT_periodo bits suffice; the
  // shifted trial value carries the extra bit.
  logic [BIT_periodo-1:0] rem;
  logic [CW-1:0]          step;

  logic [BIT_periodo:0]   rem_shift;
  logic                   take;
  logic                   sat;
  logic [8:0]             d_sat;

  always_comb begin
    rem_shift = {rem, dividend[BIT_periodo-1]};
    take      = (rem_shift >= CYC);
    sat       = (quot > MAXQ);
    d_sat     = sat ? MAX9 : quot[8:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done_q       <= 1'b1;
      dividend     <= '0;
      quot         <= '0;
      rem          <= '0;
      step         <= '0;
      distance_cm  <= '0;
      dist_valid   <= 1'b0;
      out_of_range <= 1'b0;
      obstacle     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done_q     <= done;
      dist_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (done && !done_q) begin
            dividend <= periodo;
            rem      <= '0;
            quot     <= '0;
            step     <= CW'(BIT_periodo - 1);
            busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          dividend <= {dividend[BIT_periodo-2:0], 1'b0};
          quot     <= {quot[BIT_periodo-2:0], take};
          rem      <= take ? BIT_periodo'(rem_shift - CYC) : BIT_periodo'(rem_shift);
          if (step == '0) state <= DONE;
          else            step  <= step - 1'b1;
        end
        DONE: begin
          distance_cm  <= d_sat;
          out_of_range <= sat;
          dist_valid   <= 1'b1;
          if (d_sat <= NEAR9)     obstacle <= 1'b1;
          else if (d_sat >= FAR9) obstacle <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_distance.sv
// tb/tb_echo_distance.sv - self-checking bench for echo_distance
module tb_echo_distance;
  localparam int CYC  = 2900;
  localparam int MAXC = 400;
  localparam int NEAR = 20;
  localparam int FAR  = 25;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [21:0] periodo;
  logic [8:0]  distance_cm;
  logic        dist_valid, out_of_range, obstacle, busy;

  int   checks = 0;
  int   failures = 0;
  logic model_obs;

  echo_distance dut (
    .clk(clk), .rst(rst), .periodo(periodo), .done(done),
    .distance_cm(distance_cm), .dist_valid(dist_valid),
    .out_of_range(out_of_range), .obstacle(obstacle), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_quot(input logic [21:0] p);
    return int'(p) / CYC;
  endfunction

  function automatic int ref_dist(input logic [21:0] p);
    return (ref_quot(p) > MAXC) ? MAXC : ref_quot(p);
  endfunction

  function automatic void model_update(input int d);
    if (d <= NEAR)     model_obs = 1'b1;
    else if (d >= FAR) model_obs = 1'b0;
  endfunction

  task automatic do_reset(input logic d);
    @(negedge clk);
    rst = 1'b1; done = d; periodo = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_obs = 1'b0;
  endtask

  // Fresh rising edge of done with periodo = p; lat is the strobe latency, 0 if no strobe within 40 cycles.
  task automatic convert(input logic [21:0] p, output int lat, output logic b0, output logic dv_after);
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    periodo = p; done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0 = busy;
    periodo = ~p;
    lat = 0;
    dv_after = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dist_valid) begin
        lat = k;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      dv_after = dist_valid;
    end
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++;
    if ({distance_cm, dist_valid, out_of_range, obstacle, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got dist=%0d dv=%b oor=%b obs=%b busy=%b want all 0",
               distance_cm, dist_valid, out_of_range, obstacle, busy);
    end
  endtask

  task automatic test_basic;
    int lat; logic b0, dva;
    convert(22'd29000, lat, b0, dva);
    model_update(10);
    checks++; if (lat !== 23) begin failures++; $display("FAIL basic_latency got %0d want 23", lat); end
    checks++; if (dva !== 1'b0) begin failures++; $display("FAIL basic_strobe_width got dv=%b want 0", dva); end
    checks++; if (b0 !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", b0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got %b want 0", busy); end
    checks++; if (distance_cm !== 9'd10) begin failures++; $display("FAIL basic_dist got %0d want 10", distance_cm); end
    checks++; if (obstacle !== 1'b1) begin failures++; $display("FAIL basic_obstacle got %b want 1", obstacle); end
    checks++; if (out_of_range !== 1'b0) begin failures++; $display("FAIL basic_oor got %b want 0", out_of_range); end
  endtask

  task automatic test_rounding;
    logic [21:0] pv [3] = '{22'd2899, 22'd2900, 22'd0};
    int          ev [3] = '{0, 1, 0};
    int lat; logic b0, dva;
    for (int i = 0; i < 3; i++) begin
      convert(pv[i], lat, b0, dva);
      model_update(ev[i]);
      checks++;
      if (lat !== 23 || distance_cm !== 9'(ev[i]) || obstacle !== model_obs || out_of_range !== 1'b0) begin
        failures++;
        $display("FAIL rounding p=%0d got lat=%0d dist=%0d obs=%b oor=%b want lat=23 dist=%0d obs=%b oor=0",
                 pv[i], lat, distance_cm, obstacle, out_of_range, ev[i], model_obs);
      end
    end
  endtask

  task automatic test_saturation;
    logic [21:0] pv [2] = '{22'd2000000, 22'd290000};
    int          ev [2] = '{400, 100};
    logic        eo [2] = '{1'b1, 1'b0};
    int lat; logic b0, dva;
    for (int i = 0; i < 2; i++) begin
      convert(pv[i], lat, b0, dva);
      model_update(ev[i]);
      checks++;
      if (lat !== 23 || distance_cm !== 9'(ev[i]) || out_of_range !== eo[i] || obstacle !== 1'b0) begin
        failures++;
        $display("FAIL saturation p=%0d got lat=%0d dist=%0d oor=%b obs=%b want lat=23 dist=%0d oor=%b obs=0",
                 pv[i], lat, distance_cm, out_of_range, obstacle, ev[i], eo[i]);
      end
    end
  endtask

  task automatic test_hysteresis;
    logic [21:0] pv [4] = '{22'd58000, 22'd63800, 22'd72500, 22'd63800};
    int          ev [4] = '{20, 22, 25, 22};
    logic        eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat; logic b0, dva;
    for (int i = 0; i < 4; i++) begin
      convert(pv[i], lat, b0, dva);
      model_update(ev[i]);
      checks++;
      if (lat !== 23 || distance_cm !== 9'(ev[i]) || obstacle !== eb[i]) begin
        failures++;
        $display("FAIL hysteresis step=%0d got lat=%0d dist=%0d obs=%b want lat=23 dist=%0d obs=%b",
                 i, lat, distance_cm, obstacle, ev[i], eb[i]);
      end
    end
  endtask

  task automatic test_dropped_edge;
    int nstrobe; logic [8:0] seen;
    @(negedge clk); done = 1'b0;
    @(negedge clk);
    @(negedge clk); periodo = 22'd87000; done = 1'b1;
    @(posedge clk);
    nstrobe = 0; seen = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin periodo = 22'd5800; done = 1'b0; end
      if (k == 4) done = 1'b1;
      if (dist_valid) begin nstrobe++; seen = distance_cm; end
      @(posedge clk);
    end
    model_update(30);
    checks++; if (nstrobe !== 1) begin failures++; $display("FAIL dropped_count got %0d want 1", nstrobe); end
    checks++; if (seen !== 9'd30) begin failures++; $display("FAIL dropped_value got %0d want 30", seen); end
    checks++; if (obstacle !== model_obs) begin failures++; $display("FAIL dropped_obstacle got %b want %b", obstacle, model_obs); end
  endtask

  task automatic test_stale_done;
    int nstrobe; int lat; logic b0, dva;
    do_reset(1'b1);
    nstrobe = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dist_valid) nstrobe++;
    end
    checks++; if (nstrobe !== 0) begin failures++; $display("FAIL stale_no_strobe got %0d want 0", nstrobe); end
    convert(22'd63800, lat, b0, dva);
    model_update(22);
    checks++;
    if (lat !== 23 || distance_cm !== 9'd22) begin
      failures++;
      $display("FAIL stale_then_fresh got lat=%0d dist=%0d want lat=23 dist=22", lat, distance_cm);
    end
  endtask

  task automatic test_reset_mid;
    int lat; int nstrobe; logic b0, dva;
    convert(22'd29000, lat, b0, dva);
    model_update(10);
    @(negedge clk); done = 1'b0;
    @(negedge clk);
    @(negedge clk); periodo = 22'd116000; done = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_obs = 1'b0;
    checks++;
    if ({distance_cm, dist_valid, out_of_range, obstacle, busy} !== 13'd0) begin
      failures++;
      $display("FAIL midreset_outputs got dist=%0d dv=%b oor=%b obs=%b busy=%b want all 0",
               distance_cm, dist_valid, out_of_range, obstacle, busy);
    end
    nstrobe = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dist_valid) nstrobe++;
    end
    checks++; if (nstrobe !== 0) begin failures++; $display("FAIL midreset_no_strobe got %0d want 0", nstrobe); end
    convert(22'd58000, lat, b0, dva);
    model_update(20);
    checks++;
    if (lat !== 23 || distance_cm !== 9'd20 || obstacle !== 1'b1) begin
      failures++;
      $display("FAIL midreset_recover got lat=%0d dist=%0d obs=%b want lat=23 dist=20 obs=1",
               lat, distance_cm, obstacle);
    end
  endtask

  task automatic test_random;
    logic [21:0] p; int d; logic eo; int lat; logic b0, dva;
    for (int i = 0; i < 16; i++) begin
      p = (i % 2 == 0) ? 22'($urandom_range(0, 120000)) : 22'($urandom_range(0, 4194303));
      d = ref_dist(p);
      eo = (ref_quot(p) > MAXC);
      model_update(d);
      convert(p, lat, b0, dva);
      checks++;
      if (lat !== 23 || distance_cm !== 9'(d) || out_of_range !== eo || obstacle !== model_obs) begin
        failures++;
        $display("FAIL random p=%0d got lat=%0d dist=%0d oor=%b obs=%b want lat=23 dist=%0d oor=%b obs=%b",
                 p, lat, distance_cm, out_of_range, obstacle, d, eo, model_obs);
      end
    end
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; periodo = '0; model_obs = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_hysteresis();
    test_dropped_edge();
    test_stale_done();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
